// File: rtl/bps_sweep_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// bps_sweep_scheduler_pkg
// Shared definitions for the belief-propagation sweep scheduler:
//   - sched_state_e : scheduler FSM encodings (IDLE/RUN/DRAIN/DONE)
//   - DIR_DOWN/DIR_UP : sweep direction constants
//   - log2() : ceiling log2, usable in parameter expressions
// ---------------------------------------------------------------------------
package bps_sweep_scheduler_pkg;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_RUN   = 2'd1,
    SCHED_DRAIN = 2'd2,
    SCHED_DONE  = 2'd3
  } sched_state_e;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  // Smallest r with 2**r >= value (log2(1) = 0).
  function automatic int log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bps_sweep_scheduler_if.sv
// ---------------------------------------------------------------------------
// bps_sweep_scheduler_if
// Issue/retire bus between the sweep scheduler and the memory /
// sequential-message-passer pipeline.
//   issue_valid  : issue_addr/issue_line hold a pixel to transfer
//   issue_addr   : pixel address (ADDR_WIDTH)
//   issue_line   : row slot of the pixel (LINE_WIDTH)
//   issue_stall  : downstream back-pressure
//   retire_valid : oldest outstanding pixel completed (in-order)
// Modports: master = scheduler, slave = pipeline.
// ---------------------------------------------------------------------------
interface bps_sweep_scheduler_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int LINE_WIDTH = 3
);
  logic                  issue_valid;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [LINE_WIDTH-1:0] issue_line;
  logic                  issue_stall;
  logic                  retire_valid;

  modport master (
    output issue_valid, issue_addr, issue_line,
    input  issue_stall, retire_valid
  );

  modport slave (
    input  issue_valid, issue_addr, issue_line,
    output issue_stall, retire_valid
  );
endinterface

// File: rtl/bps_tag_fifo.sv
// ---------------------------------------------------------------------------
// bps_tag_fifo
// Synchronous FIFO of slot ids for issues still in the pipeline. The head
// entry names the slot whose pixel the next retire completes.
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   push/push_data : enqueue a slot id (ignored when full)
//   pop/pop_data   : dequeue; pop_data shows the head (ignored when empty)
//   full, empty    : occupancy flags
//   count          : number of stored entries
// ---------------------------------------------------------------------------
module bps_tag_fifo
  import bps_sweep_scheduler_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 3,
  parameter int CNT_W = log2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? log2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: storage has no reset; an entry is only read after it was written,
  // and leaving it unreset lets it map onto plain RAM/flops without reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/bps_sweep_scheduler.sv
// ---------------------------------------------------------------------------
// bps_sweep_scheduler
// Walks the field in TRW-S order over LINES interleaved row slots and issues
// one pixel address per handshake. A pixel is held back until its left
// neighbour (same slot, one in flight at most) and its upper neighbour
// (previous slot) have retired.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   start      : begin a sweep (sampled only in IDLE)
//   direction  : 0 = down, 1 = up, captured with start
//   busy       : high in RUN or DRAIN
//   done       : one-cycle pulse at sweep end
//   err        : sticky, retire seen with no outstanding issue
//   bus        : issue/retire bus (master side)
//   perf_cycles, perf_bubbles : only with BPS_SCHED_STATS_EN defined
// Optional feature macro: BPS_SCHED_STATS_EN (performance counters).
// ---------------------------------------------------------------------------
module bps_sweep_scheduler
  import bps_sweep_scheduler_pkg::*;
#(
  parameter int FIELD_WIDTH  = 128,
  parameter int FIELD_HEIGHT = 128,
  parameter int LINES        = 8,
  parameter int ADDR_WIDTH   = log2(FIELD_WIDTH * FIELD_HEIGHT - 1),
  parameter int TAG_DEPTH    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic direction,
  output logic busy,
  output logic done,
  output logic err,
  bps_sweep_scheduler_if.master bus
`ifdef BPS_SCHED_STATS_EN
  , output logic [31:0] perf_cycles
  , output logic [31:0] perf_bubbles
`endif
);

  localparam int LINE_W     = (LINES > 1) ? log2(LINES) : 1;
  localparam int ROW_W      = log2(FIELD_HEIGHT + LINES);
  localparam int COL_W      = log2(FIELD_WIDTH + 1);
  localparam int TOTAL      = FIELD_WIDTH * FIELD_HEIGHT;
  localparam int CNT_W      = log2(TOTAL + 1);
  localparam int FIFO_CNT_W = log2(TAG_DEPTH + 1);

  typedef struct packed {
    logic             active;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;       // next column to issue
    logic [COL_W-1:0] ret;       // columns retired in the current row
    logic             inflight;
  } slot_t;

  slot_t                 slot_q [LINES];
  sched_state_e          state_q, state_d;
  logic                  dir_q;
  logic [LINE_W-1:0]     last_q;
  logic [CNT_W-1:0]      issued_q;

  logic                  issue_valid_q;
  logic [ADDR_WIDTH-1:0] issue_addr_q;
  logic [LINE_W-1:0]     issue_line_q;
  logic                  err_q;

  logic [LINES-1:0]      eligible;
  logic                  grant_any;
  logic [LINE_W-1:0]     grant_idx;
  logic [LINE_W-1:0]     cand;
  logic [ADDR_WIDTH-1:0] lin_addr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  can_load;
  logic                  do_issue;
  logic                  do_retire;
  logic                  last_issue;
  logic                  start_sweep;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [LINE_W-1:0]     retire_idx;
  logic [FIFO_CNT_W-1:0] fifo_count;

  bps_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .WIDTH (LINE_W),
    .CNT_W (FIFO_CNT_W)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (do_issue),
    .push_data (grant_idx),
    .pop       (do_retire),
    .pop_data  (retire_idx),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Vertical dependency: the previous slot is either already on a later row
  // (so the row above is complete) or has retired past this column.
  always_comb begin
    // NOTE: every combinationally written signal gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    eligible = '0;
    for (int k = 0; k < LINES; k++) begin
      eligible[k] = slot_q[k].active && !slot_q[k].inflight && !fifo_full &&
                    ((slot_q[k].row == '0) ||
                     (slot_q[(k + LINES - 1) % LINES].row >= slot_q[k].row) ||
                     (slot_q[(k + LINES - 1) % LINES].ret > slot_q[k].col));
    end
  end

  // Round-robin pick starting just after the last granted slot.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 1; i <= LINES; i++) begin
      cand = LINE_W'((int'(last_q) + i) % LINES);
      if (!grant_any && eligible[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign lin_addr  = ADDR_WIDTH'(slot_q[grant_idx].row) * ADDR_WIDTH'(FIELD_WIDTH) +
                     ADDR_WIDTH'(slot_q[grant_idx].col);
  assign next_addr = (dir_q == DIR_UP) ? ADDR_WIDTH'(TOTAL - 1) - lin_addr : lin_addr;

  // The output register may reload whenever it is empty or transferring.
  assign can_load    = (state_q == SCHED_RUN) && (!issue_valid_q || !bus.issue_stall);
  assign do_issue    = can_load && grant_any;
  assign do_retire   = bus.retire_valid && !fifo_empty;
  assign last_issue  = do_issue && (issued_q == CNT_W'(TOTAL - 1));
  assign start_sweep = (state_q == SCHED_IDLE) && start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      SCHED_IDLE:  if (start) state_d = SCHED_RUN;
      SCHED_RUN:   if (last_issue) state_d = SCHED_DRAIN;
      // Look ahead one cycle so done follows the final retire directly.
      SCHED_DRAIN: if (fifo_empty || (do_retire && fifo_count == FIFO_CNT_W'(1)))
                     state_d = SCHED_DONE;
      SCHED_DONE:  state_d = SCHED_IDLE;
      default:     state_d = SCHED_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= SCHED_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < LINES; k++) slot_q[k] <= '0;
      dir_q    <= DIR_DOWN;
      last_q   <= LINE_W'(LINES - 1);
      issued_q <= '0;
    end else if (start_sweep) begin
      for (int k = 0; k < LINES; k++) begin
        slot_q[k].active   <= (k < FIELD_HEIGHT);
        slot_q[k].row      <= ROW_W'(k);
        slot_q[k].col      <= '0;
        slot_q[k].ret      <= '0;
        slot_q[k].inflight <= 1'b0;
      end
      dir_q    <= direction;
      last_q   <= LINE_W'(LINES - 1);
      issued_q <= '0;
    end else begin
      // A slot being issued is never the one retiring: retire pops a slot
      // that is in flight, and only idle slots are eligible.
      for (int k = 0; k < LINES; k++) begin
        if (do_issue && grant_idx == LINE_W'(k)) begin
          slot_q[k].inflight <= 1'b1;
          slot_q[k].col      <= slot_q[k].col + COL_W'(1);
        end
        if (do_retire && retire_idx == LINE_W'(k)) begin
          slot_q[k].inflight <= 1'b0;
          if (slot_q[k].ret == COL_W'(FIELD_WIDTH - 1)) begin
            slot_q[k].row    <= slot_q[k].row + ROW_W'(LINES);
            slot_q[k].col    <= '0;
            slot_q[k].ret    <= '0;
            slot_q[k].active <= (slot_q[k].row + ROW_W'(LINES)) < ROW_W'(FIELD_HEIGHT);
          end else begin
            slot_q[k].ret    <= slot_q[k].ret + COL_W'(1);
          end
        end
      end
      if (do_issue) begin
        last_q   <= grant_idx;
        issued_q <= issued_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_valid_q <= 1'b0;
      issue_addr_q  <= '0;
      issue_line_q  <= '0;
      err_q         <= 1'b0;
    end else begin
      if (do_issue) begin
        issue_valid_q <= 1'b1;
        issue_addr_q  <= next_addr;
        issue_line_q  <= grant_idx;
      end else if (issue_valid_q && !bus.issue_stall) begin
        issue_valid_q <= 1'b0;
      end
      if (bus.retire_valid && fifo_empty) err_q <= 1'b1;
    end
  end

  assign bus.issue_valid = issue_valid_q;
  assign bus.issue_addr  = issue_addr_q;
  assign bus.issue_line  = issue_line_q;
  assign busy            = (state_q == SCHED_RUN) || (state_q == SCHED_DRAIN);
  assign done            = (state_q == SCHED_DONE);
  assign err             = err_q;

`ifdef BPS_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cycles  <= '0;
      perf_bubbles <= '0;
    end else if (start_sweep) begin
      perf_cycles  <= '0;
      perf_bubbles <= '0;
    end else begin
      if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
      if (state_q == SCHED_RUN && !bus.issue_stall && eligible == '0 && perf_bubbles != '1)
        perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bps_sweep_scheduler.sv
// ---------------------------------------------------------------------------
// tb_bps_sweep_scheduler
// Directed bench for bps_sweep_scheduler on a 4x4 field with 2 row slots.
// A downstream model transfers whenever issue_stall is low and retires each
// transferred pixel exactly 3 cycles later, in order.
// ---------------------------------------------------------------------------
module tb_bps_sweep_scheduler;
  import bps_sweep_scheduler_pkg::*;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int L  = 2;
  localparam int AW = log2(W * H - 1);
  localparam int LW = 1;
  localparam int MAX_CYC = 400;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic direction = 1'b0;
  logic busy, done, err;
`ifdef BPS_SCHED_STATS_EN
  logic [31:0] perf_cycles, perf_bubbles;
`endif

  bps_sweep_scheduler_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

  bps_sweep_scheduler #(
    .FIELD_WIDTH  (W),
    .FIELD_HEIGHT (H),
    .LINES        (L),
    .ADDR_WIDTH   (AW),
    .TAG_DEPTH    (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .direction (direction),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bus       (bus)
`ifdef BPS_SCHED_STATS_EN
    , .perf_cycles  (perf_cycles)
    , .perf_bubbles (perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Downstream model and per-sweep observations.
  int     cyc, st_from, st_to, restart_at;
  bit     cur_dir;
  bit [2:0] sh;
  int     pend_q[$];
  int     issued_cnt[W*H];
  bit     retired[W*H];
  int     first_cyc, first_addr, first_line, n_xfer, dep_viol;
  int     done_cnt, done_cyc, last_ret, unstable, held;
  logic   busy_at_done;
  bit     prev_sv;
  logic [AW-1:0] prev_addr;

  task automatic clear_model();
    sh = '0;
    pend_q.delete();
    for (int i = 0; i < W*H; i++) begin
      issued_cnt[i] = 0;
      retired[i]    = 1'b0;
    end
    first_cyc = -1; first_addr = -1; first_line = -1;
    n_xfer = 0; dep_viol = 0; done_cnt = 0; done_cyc = -1; last_ret = -1;
    unstable = 0; held = 0; busy_at_done = 1'bx; prev_sv = 1'b0; prev_addr = '0;
    st_from = -1; st_to = -1; restart_at = -1;
  endtask

  // One cycle: sample at the falling edge, then drive the next inputs.
  task automatic tick();
    int  lin;
    bit  xfer;
    @(negedge clk);
    cyc++;
    start     = (cyc == restart_at);
    direction = (cyc == restart_at) ? ~cur_dir : cur_dir;
    if (done) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
    bus.issue_stall = (cyc >= st_from) && (cyc < st_to);
    if (bus.issue_valid && first_cyc < 0) begin
      first_cyc  = cyc;
      first_addr = int'(bus.issue_addr);
      first_line = int'(bus.issue_line);
    end
    if (bus.issue_valid && bus.issue_stall) begin
      held++;
      if (prev_sv && bus.issue_addr != prev_addr) unstable++;
    end
    prev_sv   = bus.issue_valid && bus.issue_stall;
    prev_addr = bus.issue_addr;
    xfer = bus.issue_valid && !bus.issue_stall;
    if (xfer) begin
      lin = cur_dir ? (W*H - 1) - int'(bus.issue_addr) : int'(bus.issue_addr);
      if (lin >= W && !retired[lin - W]) dep_viol++;
      if ((lin % W) != 0 && !retired[lin - 1]) dep_viol++;
      issued_cnt[lin]++;
      n_xfer++;
      pend_q.push_back(lin);
    end
    bus.retire_valid = sh[2];
    if (sh[2]) begin
      if (pend_q.size() > 0) begin
        lin = pend_q.pop_front();
        retired[lin] = 1'b1;
      end
      last_ret = cyc;
    end
    sh = {sh[1:0], xfer};
  endtask

  task automatic run_sweep(input bit dir, input int sfrom, input int slen, input int rs_at);
    clear_model();
    cur_dir    = dir;
    st_from    = sfrom;
    st_to      = sfrom + slen;
    restart_at = rs_at;
    @(negedge clk);
    cyc              = 0;
    start            = 1'b1;
    direction        = dir;
    bus.issue_stall  = 1'b0;
    bus.retire_valid = 1'b0;
    while (done_cyc < 0 && cyc < MAX_CYC) tick();
    repeat (3) tick();
  endtask

  function automatic int count_unique();
    int n;
    n = 0;
    for (int i = 0; i < W*H; i++) if (issued_cnt[i] == 1) n++;
    return n;
  endfunction

  typedef struct {
    bit dir;
    int st_from;
    int st_len;
    int restart_at;
    int exp_first_addr;
    int exp_first_line;
    int exp_issues;
    int exp_err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int done_seen;

    vecs[0] = '{dir: DIR_DOWN, st_from: -1, st_len: 0, restart_at: -1, exp_first_addr: 0,  exp_first_line: 0, exp_issues: 16, exp_err: 0};
    vecs[1] = '{dir: DIR_UP,   st_from: -1, st_len: 0, restart_at: -1, exp_first_addr: 15, exp_first_line: 0, exp_issues: 16, exp_err: 0};
    vecs[2] = '{dir: DIR_DOWN, st_from: 8,  st_len: 5, restart_at: -1, exp_first_addr: 0,  exp_first_line: 0, exp_issues: 16, exp_err: 0};
    vecs[3] = '{dir: DIR_DOWN, st_from: -1, st_len: 0, restart_at: 6,  exp_first_addr: 0,  exp_first_line: 0, exp_issues: 16, exp_err: 0};
    vecs[4] = '{dir: DIR_UP,   st_from: 10, st_len: 5, restart_at: -1, exp_first_addr: 15, exp_first_line: 0, exp_issues: 16, exp_err: 0};

    // Reset state.
    rst = 1'b0;
    bus.issue_stall  = 1'b0;
    bus.retire_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_issue_valid", bus.issue_valid, 0);
    check("rst_issue_addr",  bus.issue_addr,  0);
    check("rst_issue_line",  bus.issue_line,  0);
    check("rst_busy",        busy,            0);
    check("rst_done",        done,            0);
    check("rst_err",         err,             0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_sweep(vecs[i].dir, vecs[i].st_from, vecs[i].st_len, vecs[i].restart_at);
      check($sformatf("v%0d_finished",    i), done_cyc >= 0, 1);
      check($sformatf("v%0d_first_cycle", i), first_cyc, 2);
      check($sformatf("v%0d_first_addr",  i), first_addr, vecs[i].exp_first_addr);
      check($sformatf("v%0d_first_line",  i), first_line, vecs[i].exp_first_line);
      check($sformatf("v%0d_issues",      i), n_xfer, vecs[i].exp_issues);
      check($sformatf("v%0d_unique",      i), count_unique(), vecs[i].exp_issues);
      check($sformatf("v%0d_dep_order",   i), dep_viol, 0);
      check($sformatf("v%0d_done_pulses", i), done_cnt, 1);
      check($sformatf("v%0d_done_timing", i), done_cyc, last_ret + 1);
      check($sformatf("v%0d_busy_at_done", i), busy_at_done, 0);
      check($sformatf("v%0d_stall_hold",  i), unstable, 0);
      check($sformatf("v%0d_stall_seen",  i), held > 0, vecs[i].st_len > 0);
      check($sformatf("v%0d_err",         i), err, vecs[i].exp_err);
    end

    // Retire with nothing outstanding sets a sticky err.
    @(negedge clk);
    bus.retire_valid = 1'b1;
    @(negedge clk);
    bus.retire_valid = 1'b0;
    check("idle_retire_err", err, 1);
    run_sweep(DIR_DOWN, -1, 0, -1);
    check("err_sweep_issues", count_unique(), 16);
    check("err_sweep_done",   done_cnt, 1);
    check("err_sticky",       err, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("err_cleared", err, 0);
    @(negedge clk);
    rst = 1'b1;

    // Reset in the middle of a sweep abandons it.
    clear_model();
    cur_dir = DIR_DOWN;
    @(negedge clk);
    cyc = 0;
    start = 1'b1;
    direction = DIR_DOWN;
    repeat (8) tick();
    check("mid_busy_before", busy, 1);
    @(negedge clk);
    rst = 1'b0;
    bus.retire_valid = 1'b0;
    bus.issue_stall  = 1'b0;
    #1;
    check("abort_busy",        busy, 0);
    check("abort_issue_valid", bus.issue_valid, 0);
    done_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    run_sweep(DIR_DOWN, -1, 0, -1);
    check("after_abort_first_addr", first_addr, 0);
    check("after_abort_first_line", first_line, 0);
    check("after_abort_unique",     count_unique(), 16);
    check("after_abort_dep_order",  dep_viol, 0);
    check("after_abort_done",       done_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bps_sweep_scheduler.md
# bps_sweep_scheduler

Issue scheduler for the belief-propagation sweep datapath. It walks the field in TRW-S order, forward (down) or reverse (up), over up to `LINES` interleaved row slots. It emits one pixel address per handshake to the memory/sequential-message-passer pipeline and holds back any pixel whose vertical (row above) or horizontal (left neighbour) message has not yet retired. It replaces the ad-hoc `line`/`active_lines`/`phase_addr` sequencing inside the BP solver top level.

## Interface
- `FIELD_WIDTH`, 128: pixels per row
- `FIELD_HEIGHT`, 128: rows
- `LINES`, 8: row slots in flight (power of 2, ≤ `FIELD_HEIGHT`)
- `ADDR_WIDTH`, log2(FIELD_WIDTH*FIELD_HEIGHT-1): pixel address width
- `TAG_DEPTH`, 16: outstanding-issue tag FIFO depth (≥ pipeline latency)

Ports:
- `clk` in 1: clock, rising edge
- `rst` in 1: reset, asynchronous, active-low
- `start` in 1: begin sweep; sampled only in IDLE
- `direction` in 1: 0 = down, 1 = up; captured with `start`
- `busy` out 1: high in RUN or DRAIN
- `done` out 1: one-cycle pulse at sweep end
- `issue_valid` out 1: `issue_addr` and `issue_line` are valid
- `issue_addr` out ADDR_WIDTH: pixel address
- `issue_line` out log2(LINES): slot index of the issue
- `issue_stall` in 1: downstream back-pressure
- `retire_valid` in 1: oldest outstanding pixel completed (in-order pipeline)
- `err` out 1: sticky; retire seen with no outstanding tag

## Operation
- States:
  - IDLE: on `start`, go to RUN.
  - RUN: once the last pixel has issued, go to DRAIN.
  - DRAIN: once the tag FIFO is empty, go to DONE.
  - DONE: one cycle, `done`=1, then return to IDLE.
- `start` outside IDLE is ignored.
- Slot k initially owns row k and is active iff k < FIELD_HEIGHT. Per slot: `row`, `col` (next to issue), `ret` (retired count in current row), `inflight` (≤1).
- Slot k is eligible when all of the following hold:
  - it is active and `!inflight`;
  - the tag FIFO is not full;
  - vertical dependency is met: `row`==0, or the previous slot (k-1 mod LINES) has `row` > this `row`-1, or `ret` of the previous slot > `col`.
- Grant: round-robin among eligible slots, starting after the last granted slot. At most one grant per cycle.
- Linear address = `row`*FIELD_WIDTH + `col`. For up sweeps, `issue_addr` = FIELD_WIDTH*FIELD_HEIGHT-1 − linear.
- On issue:
  - the slot id is pushed to the tag FIFO;
  - `inflight` is set;
  - `col` increments.
- On `retire_valid`:
  - the FIFO is popped and that slot's `inflight` is cleared;
  - `ret` increments.
  - When `ret` reaches FIELD_WIDTH: `row` += LINES, `col` = `ret` = 0. If the new `row` ≥ FIELD_HEIGHT, the slot goes inactive.
- Issue and retire in the same cycle are both applied. A retire does not make its own slot eligible until the next cycle.
- `retire_valid` with an empty FIFO sets `err` and is otherwise ignored. `err` clears only on reset.

## Timing
- Reset values: all outputs 0, state IDLE, FIFO empty, all slots cleared. Reset mid-sweep abandons the sweep. No `done` is produced.
- `start` at edge t → RUN at t+1 → first `issue_valid` at t+2.
- Output handshake:
  - `issue_*` are registered.
  - A transfer occurs on any cycle with `issue_valid`=1 and `issue_stall`=0.
  - While stalled, `issue_addr` and `issue_line` hold and no new grant is made.
  - A new grant may load on the same cycle a transfer completes, giving 1 issue/cycle throughput.
- Dependency latency: a retire at cycle t unblocks a dependent pixel, which can be `issue_valid` at t+2 at the earliest.
- `done` is asserted the cycle after the final retire; `busy` falls in the same cycle `done` rises.

## Configuration
- `BPS_SCHED_STATS_EN`:
  - Defined: adds outputs `perf_cycles` [31:0] (cycles in RUN or DRAIN) and `perf_bubbles` [31:0] (RUN cycles with `issue_stall`=0 and no eligible slot). Both clear on `start` and saturate at all-ones.
  - Undefined: the ports and counters are absent. The scheduling behaviour is identical either way.

## Structure
- Shared BP package holds:
  - state encodings (`SCHED_IDLE`/`RUN`/`DRAIN`/`DONE`);
  - direction constants `DIR_DOWN`=0 and `DIR_UP`=1;
  - the `log2` helper.
- One sub-module: `bps_tag_fifo` (synchronous FIFO of slot ids, depth `TAG_DEPTH`, outputs full/empty).

## Test plan
Benches use FIELD_WIDTH=4, FIELD_HEIGHT=4, LINES=2 unless noted.
- Reset: hold `rst`=0 → all outputs 0. Release and pulse `start` with `issue_stall`=0 → first issue is addr 0, line 0.
- Down sweep, fixed retire latency 3: addr 4 (row 1, col 0) is not issued before addr 0 retires. Exactly 16 unique addresses 0..15 are issued, then `done` pulses once and `err` stays 0.
- Up sweep with `direction`=1: first issue addr 15, line 0. Addr 11 is not issued before addr 15 retires. Completes after 16 issues.
- Hold `issue_stall`=1 for 5 cycles mid-sweep: `issue_addr` is stable throughout, and no address is duplicated or dropped over the sweep.
- Pulse `retire_valid` while IDLE → `err`=1 and stays 1 through a following full sweep. Assert `rst`=0 → `err`=0.
- Pulse `start` during RUN → ignored. Assert `rst`=0 mid-sweep → `busy`=0 and no `done`. A subsequent `start` sweeps correctly from addr 0.
